// File: rtl/decode_pipe_stage.sv
// rtl/decode_pipe_stage.sv - registered decode stage: RF, format/immediate decode, load-use stall, halt FSM
// Optional macro FORWARD_WB_EN: bypass write-back data into operands on accept and while held.
module decode_pipe_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 16,
  localparam int RA_W    = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_instr,
  input  logic [XLEN-1:0]   i_pc,
  input  logic              i_flush,
  input  logic              i_wb_en,
  input  logic [RA_W-1:0]   i_wb_addr,
  input  logic [XLEN-1:0]   i_wb_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [XLEN-1:0]   o_pc,
  output logic [RA_W-1:0]   o_rs1_addr,
  output logic [RA_W-1:0]   o_rs2_addr,
  output logic [RA_W-1:0]   o_rd_addr,
  output logic [XLEN-1:0]   o_rs1_data,
  output logic [XLEN-1:0]   o_rs2_data,
  output logic [XLEN-1:0]   o_imm,
  output logic [5:0]        o_format,
  output logic [2:0]        o_funct3,
  output logic [6:0]        o_funct7,
  output logic              o_is_load,
  output logic              o_illegal,
  output logic              o_halt,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic {RUN, HALTED} state_t;
  state_t state, state_next;

  logic [XLEN-1:0] rf [NUM_REGS];
  logic [6:0]      opcode;
  logic [RA_W-1:0] rs1, rs2, rd;
  logic [5:0]      fmt;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_x;
  logic            illegal, is_load, rs2_used, hazard, accept;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign opcode  = i_instr[6:0];
  assign rs1     = i_instr[15 +: RA_W];
  assign rs2     = i_instr[20 +: RA_W];
  assign rd      = i_instr[7 +: RA_W];
  assign is_load = (opcode == 7'b0000011);

  always_comb begin
    fmt     = 6'b000000;
    imm32   = 32'h0;
    illegal = 1'b0;
    case (opcode)
      7'b0110011: fmt = 6'b000001;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        fmt   = 6'b000010;
        imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      7'b0100011: begin
        fmt   = 6'b000100;
        imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      7'b1100011: begin
        fmt   = 6'b001000;
        imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        fmt   = 6'b010000;
        imm32 = {i_instr[31:12], 12'h000};
      end
      7'b1101111: begin
        fmt   = 6'b100000;
        imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      end
      default: illegal = 1'b1;
    endcase
  end

  assign imm_x    = XLEN'($signed(imm32));
  assign rs2_used = fmt[0] | fmt[2] | fmt[3];

  // Only a load sitting in the output register can create a load-use hazard.
  assign hazard = o_valid & o_is_load & (o_rd_addr != '0) &
                  ((o_rd_addr == rs1) | (rs2_used & (o_rd_addr == rs2)));
  assign o_ready = (!o_valid | i_ready) & !hazard & !i_flush & (state == RUN);
  assign accept  = i_valid & o_ready;
  assign o_halt  = (state == HALTED);

  always_comb begin
    rs1_val = (rs1 == '0) ? '0 : rf[rs1];
    rs2_val = (rs2 == '0) ? '0 : rf[rs2];
`ifdef FORWARD_WB_EN
    if (i_wb_en && i_wb_addr == rs1 && rs1 != '0) rs1_val = i_wb_data;
    if (i_wb_en && i_wb_addr == rs2 && rs2 != '0) rs2_val = i_wb_data;
`endif
  end

  always_comb begin
    state_next = state;
    if (state == RUN && accept && i_instr == EBREAK) state_next = HALTED;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= RUN;
    else       state <= state_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (i_wb_en && i_wb_addr != '0) begin
      rf[i_wb_addr] <= i_wb_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid     <= 1'b0;
      o_pc        <= '0;
      o_rs1_addr  <= '0;
      o_rs2_addr  <= '0;
      o_rd_addr   <= '0;
      o_rs1_data  <= '0;
      o_rs2_data  <= '0;
      o_imm       <= '0;
      o_format    <= '0;
      o_funct3    <= '0;
      o_funct7    <= '0;
      o_is_load   <= 1'b0;
      o_illegal   <= 1'b0;
      o_stall_cnt <= '0;
    end else begin
      if (i_flush) begin
        o_valid <= 1'b0;
      end else if (accept) begin
        o_valid    <= 1'b1;
        o_pc       <= i_pc;
        o_rs1_addr <= rs1;
        o_rs2_addr <= rs2;
        o_rd_addr  <= rd;
        o_rs1_data <= rs1_val;
        o_rs2_data <= rs2_val;
        o_imm      <= imm_x;
        o_format   <= fmt;
        o_funct3   <= i_instr[14:12];
        o_funct7   <= i_instr[31:25];
        o_is_load  <= is_load;
        o_illegal  <= illegal;
      end else if (i_ready) begin
        o_valid <= 1'b0;
`ifdef FORWARD_WB_EN
      end else if (o_valid) begin
        if (i_wb_en && i_wb_addr == o_rs1_addr && o_rs1_addr != '0) o_rs1_data <= i_wb_data;
        if (i_wb_en && i_wb_addr == o_rs2_addr && o_rs2_addr != '0) o_rs2_data <= i_wb_data;
`endif
      end
      if (i_valid && hazard && i_ready && !i_flush && o_stall_cnt != '1)
        o_stall_cnt <= o_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_pipe_stage.sv
// tb/tb_decode_pipe_stage.sv - directed plus random checks of decode_pipe_stage against a behavioural model
module tb_decode_pipe_stage;
  localparam int XLEN = 32;
  localparam int NR   = 32;
  localparam int CW   = 4;

  logic clk, rst, valid, ready_o, flush, wb_en, valid_o, ready_in, is_load, illegal, halt;
  logic [31:0] instr, pc, wb_data, pc_o, rs1_d, rs2_d, imm;
  logic [4:0]  wb_addr, rs1_a, rs2_a, rd_a;
  logic [5:0]  fmt;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [CW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  decode_pipe_stage #(.XLEN(XLEN), .NUM_REGS(NR), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready_o), .i_instr(instr), .i_pc(pc),
    .i_flush(flush), .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .o_valid(valid_o), .i_ready(ready_in), .o_pc(pc_o), .o_rs1_addr(rs1_a), .o_rs2_addr(rs2_a),
    .o_rd_addr(rd_a), .o_rs1_data(rs1_d), .o_rs2_data(rs2_d), .o_imm(imm), .o_format(fmt),
    .o_funct3(f3), .o_funct7(f7), .o_is_load(is_load), .o_illegal(illegal), .o_halt(halt),
    .o_stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [5:0]  fmt;
    logic [31:0] imm;
    logic        ill;
    logic        ld;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t d;
    d.fmt = 6'd0; d.imm = 32'd0; d.ill = 1'b0; d.ld = (w[6:0] == 7'h03);
    case (w[6:0])
      7'h33: d.fmt = 6'b000001;
      7'h13, 7'h03, 7'h67, 7'h73: begin d.fmt = 6'b000010; d.imm = {{20{w[31]}}, w[31:20]}; end
      7'h23: begin d.fmt = 6'b000100; d.imm = {{20{w[31]}}, w[31:25], w[11:7]}; end
      7'h63: begin d.fmt = 6'b001000; d.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0}; end
      7'h37, 7'h17: begin d.fmt = 6'b010000; d.imm = {w[31:12], 12'd0}; end
      7'h6F: begin d.fmt = 6'b100000; d.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0}; end
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction

  // Reference state: architectural registers plus the issued bundle.
  logic [31:0] m_rf [NR];
  logic m_valid, m_halt, m_ld, m_ill;
  logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [4:0]  m_rs1a, m_rs2a, m_rda;
  logic [5:0]  m_fmt;
  logic [2:0]  m_f3;
  logic [6:0]  m_f7;
  int          m_cnt;

  function automatic logic [31:0] read_reg(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef FORWARD_WB_EN
    if (wb_en && wb_addr == a) return wb_data;
`endif
    return m_rf[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_rf[i] = 32'd0;
    m_valid = 0; m_halt = 0; m_ld = 0; m_ill = 0; m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
    m_rs1a = 0; m_rs2a = 0; m_rda = 0; m_fmt = 0; m_f3 = 0; m_f7 = 0; m_cnt = 0;
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] w, input logic fl,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic rdy);
    dec_t d;
    logic hz, exp_rdy;
    rst = r; valid = v; instr = w; flush = fl; wb_en = we; wb_addr = wa; wb_data = wd;
    ready_in = rdy; pc = $urandom;
    #1;
    d  = decode(w);
    hz = m_valid && m_ld && m_rda != 0 &&
         (m_rda == w[19:15] || ((d.fmt == 6'b000001 || d.fmt == 6'b000100 || d.fmt == 6'b001000)
                                && m_rda == w[24:20]));
    exp_rdy = (!m_valid || rdy) && !hz && !fl && !m_halt;
    check_eq("o_ready", ready_o, exp_rdy);
    if (r) begin
      model_reset();
    end else begin
      if (v && hz && rdy && !fl && m_cnt < (1 << CW) - 1) m_cnt++;
      if (fl) m_valid = 0;
      else if (v && exp_rdy) begin
        m_valid = 1; m_pc = pc; m_rs1a = w[19:15]; m_rs2a = w[24:20]; m_rda = w[11:7];
        m_rs1d = read_reg(w[19:15]); m_rs2d = read_reg(w[24:20]);
        m_imm = d.imm; m_fmt = d.fmt; m_f3 = w[14:12]; m_f7 = w[31:25]; m_ld = d.ld; m_ill = d.ill;
        if (w == 32'h0010_0073) m_halt = 1;
      end else if (rdy) m_valid = 0;
`ifdef FORWARD_WB_EN
      else if (m_valid && we) begin
        if (wa == m_rs1a && wa != 0) m_rs1d = wd;
        if (wa == m_rs2a && wa != 0) m_rs2d = wd;
      end
`endif
      if (we && wa != 0) m_rf[wa] = wd;
    end
    @(posedge clk);
    #1;
    check_eq("o_valid", valid_o, m_valid);
    check_eq("o_pc", pc_o, m_pc);
    check_eq("o_rs1_addr", rs1_a, m_rs1a);
    check_eq("o_rs2_addr", rs2_a, m_rs2a);
    check_eq("o_rd_addr", rd_a, m_rda);
    check_eq("o_rs1_data", rs1_d, m_rs1d);
    check_eq("o_rs2_data", rs2_d, m_rs2d);
    check_eq("o_imm", imm, m_imm);
    check_eq("o_format", fmt, m_fmt);
    check_eq("o_funct3", f3, m_f3);
    check_eq("o_funct7", f7, m_f7);
    check_eq("o_is_load", is_load, m_ld);
    check_eq("o_illegal", illegal, m_ill);
    check_eq("o_halt", halt, m_halt);
    check_eq("o_stall_cnt", stall_cnt, m_cnt);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [13] = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h03, 7'h67, 7'h73,
                             7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    logic [31:0] w;
    int k;
    if ($urandom_range(0, 99) == 0) return 32'h0010_0073;
    w = $urandom;
    k = $urandom_range(0, 13);
    w[6:0]   = (k == 13) ? 7'($urandom) : ops[k];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  localparam logic [31:0] ADD3  = 32'h0002_81B3;  // add  x3,x5,x0
  localparam logic [31:0] ADDI1 = 32'hFFF0_0093;  // addi x1,x0,-1
  localparam logic [31:0] LW2   = 32'h0000_A103;  // lw   x2,0(x1)
  localparam logic [31:0] ADD4  = 32'h0031_0233;  // add  x4,x2,x3

  initial begin
    model_reset();
    step(1, 0, 0, 0, 0, 0, 0, 1);
    check_eq("rst_valid", valid_o, 0);
    check_eq("rst_cnt", stall_cnt, 0);
    step(0, 0, 0, 0, 1, 5'd5, 32'h1234, 1);
    step(0, 1, ADD3, 0, 0, 0, 0, 1);
    check_eq("add_valid", valid_o, 1);
    check_eq("add_rs1", rs1_d, 32'h1234);
    check_eq("add_fmt", fmt, 6'b000001);
    step(0, 1, ADDI1, 0, 0, 0, 0, 1);
    check_eq("addi_imm", imm, 32'hFFFF_FFFF);
    check_eq("addi_fmt", fmt, 6'b000010);
    step(0, 1, 32'h0000_007F, 0, 0, 0, 0, 1);
    check_eq("ill_flag", illegal, 1);
    check_eq("ill_imm", imm, 0);
    step(0, 1, LW2, 0, 0, 0, 0, 1);
    step(0, 1, ADD4, 0, 0, 0, 0, 1);
    check_eq("bubble_valid", valid_o, 0);
    check_eq("bubble_cnt", stall_cnt, 1);
    step(0, 1, ADD4, 0, 0, 0, 0, 1);
    check_eq("after_bubble_valid", valid_o, 1);
    check_eq("after_bubble_rd", rd_a, 4);
    step(0, 0, 0, 0, 1, 5'd3, 32'hAA, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("held_valid", valid_o, 1);
    check_eq("held_rd", rd_a, 4);
`ifdef FORWARD_WB_EN
    check_eq("held_fwd_rs2", rs2_d, 32'hAA);
`else
    check_eq("held_rs2", rs2_d, 32'h0);
`endif
    step(0, 1, ADDI1, 1, 0, 0, 0, 0);
    check_eq("flush_valid", valid_o, 0);
    check_eq("flush_cnt", stall_cnt, 1);
    step(0, 1, 32'h0010_0073, 0, 0, 0, 0, 1);
    check_eq("ebreak_halt", halt, 1);
    check_eq("ebreak_valid", valid_o, 1);
    step(0, 1, ADDI1, 0, 0, 0, 0, 1);
    check_eq("halted_ready", ready_o, 0);
    check_eq("halted_drain", valid_o, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check_eq("unhalt", halt, 0);
    check_eq("unhalt_ready", ready_o, 1);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, LW2, 0, 0, 0, 0, 1);
      step(0, 1, ADD4, 0, 0, 0, 0, 1);
      step(0, 1, ADD4, 0, 0, 0, 0, 1);
    end
    check_eq("stall_sat", stall_cnt, (1 << CW) - 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      step(m_halt ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 299) == 0),
           $urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 15) == 0,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) != 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
